// File: rtl/fighter_pkg.sv
// ============================================================================
// Module   : fighter_pkg
// Purpose  : Shared state encoding, box geometry offsets and box helpers for
//            the fighter controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fighter_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FWD         = 4'd1,
        ST_BACK        = 4'd2,
        ST_ATK_START   = 4'd3,
        ST_ATK_ACTIVE  = 4'd4,
        ST_ATK_RECOVER = 4'd5,
        ST_HITSTUN     = 4'd6
    } state_e;

    localparam int c_HIT_Y1  = 24;
    localparam int c_HIT_Y2  = 57;
    localparam int c_HURT_X1 = 37;
    localparam int c_BODY_X  = 86;   // hurtbox right edge and hitbox left edge
    localparam int c_HIT_X2  = 130;
    localparam int c_HURT_H  = 150;

    // Boxes are built at this width; X_W must not exceed it.
    localparam int c_BOX_W = 16;

    typedef struct packed {
        logic [c_BOX_W-1:0] x1;
        logic [c_BOX_W-1:0] x2;
        logic [c_BOX_W-1:0] y1;
        logic [c_BOX_W-1:0] y2;
    } box_t;

    // A right-side player mirrors each x offset about the sprite width.
    function automatic box_t hitbox_of(input int side, input int posx,
                                       input int sprite_w, input int pos_y);
        box_t b;
        b.y1 = c_BOX_W'(pos_y + c_HIT_Y1);
        b.y2 = c_BOX_W'(pos_y + c_HIT_Y2);
        if (side == 0) begin
            b.x1 = c_BOX_W'(posx + c_BODY_X);
            b.x2 = c_BOX_W'(posx + c_HIT_X2);
        end else begin
            b.x1 = c_BOX_W'(posx + sprite_w - c_HIT_X2);
            b.x2 = c_BOX_W'(posx + sprite_w - c_BODY_X);
        end
        return b;
    endfunction

    function automatic box_t hurtbox_of(input int side, input int posx,
                                        input int sprite_w, input int pos_y);
        box_t b;
        b.y1 = c_BOX_W'(pos_y);
        b.y2 = c_BOX_W'(pos_y + c_HURT_H);
        if (side == 0) begin
            b.x1 = c_BOX_W'(posx + c_HURT_X1);
            b.x2 = c_BOX_W'(posx + c_BODY_X);
        end else begin
            b.x1 = c_BOX_W'(posx + sprite_w - c_BODY_X);
            b.x2 = c_BOX_W'(posx + sprite_w - c_HURT_X1);
        end
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/phase_timer.sv
// ============================================================================
// Module   : phase_timer
// Purpose  : Saturating cycle counter with clear; done flags the last cycle
//            of a phase whose length is supplied at runtime.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] len,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (r_count != {W{1'b1}}) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == (len - 1'b1));

endmodule

`default_nettype wire

// File: rtl/fighter_ctrl.sv
// ============================================================================
// Module   : fighter_ctrl
// Purpose  : Per-player fighter state machine with clamped movement, attack
//            phases and mirrored hit/hurt boxes. Define FIGHTER_HITSTUN_EN to
//            compile in the hitstun/knockback reaction to the hit input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fighter_ctrl
    import fighter_pkg::*;
#(
    parameter int SIDE      = 0,
    parameter int X_W       = 10,
    parameter int SPEED     = 15,
    parameter int X_MIN     = 50,
    parameter int X_MAX     = 490,
    parameter int X_RST_L   = 210,
    parameter int X_RST_R   = 420,
    parameter int POS_Y     = 170,
    parameter int SPRITE_W  = 150,
    parameter int T_START   = 4,
    parameter int T_ACTIVE  = 1,
    parameter int T_RECOVER = 15,
    parameter int T_HITSTUN = 12,
    parameter int KNOCKBACK = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           left,
    input  logic           right,
    input  logic           attack,
    input  logic           hit,
    output logic [X_W-1:0] posx,
    output logic [X_W-1:0] posy,
    output logic [3:0]     state,
    output logic           attack_active,
    output logic [X_W-1:0] hitbox_x1,
    output logic [X_W-1:0] hitbox_x2,
    output logic [X_W-1:0] hitbox_y1,
    output logic [X_W-1:0] hitbox_y2,
    output logic [X_W-1:0] hurtbox_x1,
    output logic [X_W-1:0] hurtbox_x2,
    output logic [X_W-1:0] hurtbox_y1,
    output logic [X_W-1:0] hurtbox_y2
);

    localparam int c_TW = 8;

`ifdef FIGHTER_HITSTUN_EN
    localparam logic c_HIT_EN = 1'b1;
`else
    localparam logic c_HIT_EN = 1'b0;
`endif

    localparam logic [X_W-1:0] c_POSX_RST = X_W'((SIDE == 0) ? X_RST_L : X_RST_R);
    localparam int c_FWD_DELTA = (SIDE == 0) ? SPEED : -SPEED;
    localparam int c_KB_DELTA  = (SIDE == 0) ? -KNOCKBACK : KNOCKBACK;

    localparam logic signed [X_W:0] c_STEP_FWD  = (X_W+1)'(c_FWD_DELTA);
    localparam logic signed [X_W:0] c_STEP_BACK = (X_W+1)'(-c_FWD_DELTA);
    localparam logic signed [X_W:0] c_STEP_KB   = (X_W+1)'(c_KB_DELTA);
    localparam logic signed [X_W:0] c_MIN_S     = (X_W+1)'(X_MIN);
    localparam logic signed [X_W:0] c_MAX_S     = (X_W+1)'(X_MAX);

    logic [3:0]             r_state;
    logic [X_W-1:0]         r_posx;
    logic                   r_attack_active;
    logic [3:0]             w_next;
    logic                   w_hit;
    logic                   w_fwd_in;
    logic                   w_back_in;
    logic [c_TW-1:0]        w_len;
    logic                   w_done;
    logic                   w_clr;
    logic signed [X_W:0]    w_step;
    logic signed [X_W:0]    w_sum;
    logic [X_W-1:0]         w_posx_next;
    box_t                   w_hit_b;
    box_t                   w_hurt_b;
    logic                   w_box_unused;

    assign w_hit = hit & c_HIT_EN;

    generate
        if (SIDE == 0) begin : g_side_left
            assign w_fwd_in  = right;
            assign w_back_in = left;
        end else begin : g_side_right
            assign w_fwd_in  = left;
            assign w_back_in = right;
        end
    endgenerate

    always_comb begin
        w_len = c_TW'(1);
        case (r_state)
            ST_ATK_START:   w_len = c_TW'(T_START);
            ST_ATK_ACTIVE:  w_len = c_TW'(T_ACTIVE);
            ST_ATK_RECOVER: w_len = c_TW'(T_RECOVER);
            ST_HITSTUN:     w_len = c_TW'(T_HITSTUN);
            default:        w_len = c_TW'(1);
        endcase
    end

    // Counter restarts whenever the state register is about to change.
    assign w_clr = (w_next != r_state);

    phase_timer #(
        .W   (c_TW)
    ) u_phase_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .len  (w_len),
        .done (w_done)
    );

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE, ST_FWD, ST_BACK: begin
                if (w_hit)              w_next = ST_HITSTUN;
                else if (attack)        w_next = ST_ATK_START;
                else if (left && right) w_next = ST_BACK;
                else if (w_fwd_in)      w_next = ST_FWD;
                else if (w_back_in)     w_next = ST_BACK;
                else                    w_next = ST_IDLE;
            end
            ST_ATK_START: begin
                if (w_hit)       w_next = ST_HITSTUN;
                else if (w_done) w_next = ST_ATK_ACTIVE;
                else             w_next = ST_ATK_START;
            end
            ST_ATK_ACTIVE: begin
                if (w_hit)       w_next = ST_HITSTUN;
                else if (w_done) w_next = ST_ATK_RECOVER;
                else             w_next = ST_ATK_ACTIVE;
            end
            ST_ATK_RECOVER: begin
                if (w_hit)       w_next = ST_HITSTUN;
                else if (w_done) w_next = ST_IDLE;
                else             w_next = ST_ATK_RECOVER;
            end
            ST_HITSTUN: begin
                w_next = w_done ? ST_IDLE : ST_HITSTUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_step = '0;
        case (r_state)
            ST_FWD:     w_step = c_STEP_FWD;
            ST_BACK:    w_step = c_STEP_BACK;
            ST_HITSTUN: w_step = c_STEP_KB;
            default:    w_step = '0;
        endcase
    end

    // One extra signed bit keeps the sum from wrapping before the clamp.
    assign w_sum = $signed({1'b0, r_posx}) + w_step;

    always_comb begin
        if (w_sum > c_MAX_S)      w_posx_next = X_W'(X_MAX);
        else if (w_sum < c_MIN_S) w_posx_next = X_W'(X_MIN);
        else                      w_posx_next = w_sum[X_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_posx          <= c_POSX_RST;
            r_attack_active <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_posx          <= w_posx_next;
            r_attack_active <= (w_next == ST_ATK_ACTIVE);
        end
    end

    assign w_hit_b  = hitbox_of(SIDE, int'(r_posx), SPRITE_W, POS_Y);
    assign w_hurt_b = hurtbox_of(SIDE, int'(r_posx), SPRITE_W, POS_Y);
    assign w_box_unused = ^{w_hit_b, w_hurt_b};

    assign posx          = r_posx;
    assign posy          = X_W'(POS_Y);
    assign state         = r_state;
    assign attack_active = r_attack_active;
    assign hitbox_x1     = w_hit_b.x1[X_W-1:0];
    assign hitbox_x2     = w_hit_b.x2[X_W-1:0];
    assign hitbox_y1     = w_hit_b.y1[X_W-1:0];
    assign hitbox_y2     = w_hit_b.y2[X_W-1:0];
    assign hurtbox_x1    = w_hurt_b.x1[X_W-1:0];
    assign hurtbox_x2    = w_hurt_b.x2[X_W-1:0];
    assign hurtbox_y1    = w_hurt_b.y1[X_W-1:0];
    assign hurtbox_y2    = w_hurt_b.y2[X_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_fighter_ctrl.sv
// ============================================================================
// Module   : tb_fighter_ctrl
// Purpose  : Directed bench for a left (SIDE 0) and right (SIDE 1) fighter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fighter_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic l0 = 0, r0 = 0, a0 = 0, h0 = 0;
    logic l1 = 0, r1 = 0, a1 = 0, h1 = 0;

    logic [9:0] posx0, posy0, hb0_x1, hb0_x2, hb0_y1, hb0_y2;
    logic [9:0] hu0_x1, hu0_x2, hu0_y1, hu0_y2;
    logic [3:0] st0;
    logic       act0;
    logic [9:0] posx1, posy1, hb1_x1, hb1_x2, hb1_y1, hb1_y2;
    logic [9:0] hu1_x1, hu1_x2, hu1_y1, hu1_y2;
    logic [3:0] st1;
    logic       act1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fighter_ctrl #(.SIDE(0)) u_dut0 (
        .clk(clk), .rst(rst), .left(l0), .right(r0), .attack(a0), .hit(h0),
        .posx(posx0), .posy(posy0), .state(st0), .attack_active(act0),
        .hitbox_x1(hb0_x1), .hitbox_x2(hb0_x2), .hitbox_y1(hb0_y1), .hitbox_y2(hb0_y2),
        .hurtbox_x1(hu0_x1), .hurtbox_x2(hu0_x2), .hurtbox_y1(hu0_y1), .hurtbox_y2(hu0_y2)
    );

    fighter_ctrl #(.SIDE(1)) u_dut1 (
        .clk(clk), .rst(rst), .left(l1), .right(r1), .attack(a1), .hit(h1),
        .posx(posx1), .posy(posy1), .state(st1), .attack_active(act1),
        .hitbox_x1(hb1_x1), .hitbox_x2(hb1_x2), .hitbox_y1(hb1_y1), .hitbox_y2(hb1_y2),
        .hurtbox_x1(hu1_x1), .hurtbox_x2(hu1_x2), .hurtbox_y1(hu1_y1), .hurtbox_y2(hu1_y2)
    );

    typedef struct {
        bit l;
        bit r;
        bit a;
        int st;
        int px;
        bit act;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {l0, r0, a0, h0, l1, r1, a1, h1} = '0;
        tick();
        rst = 1'b0;
    endtask

    function automatic int exp_atk(input int i, input bit held);
        if (i < 4)       return 3;
        else if (i == 4) return 4;
        else if (i < 20) return 5;
        else if (i == 20) return 0;
        else             return held ? 3 : 0;
    endfunction

    // Attack from a fresh reset at posx 210; trace n cycles after the press.
    task automatic run_atk(input bit held, input int n);
        int e;
        do_reset();
        a0 = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (!held) a0 = 1'b0;
            e = exp_atk(i, held);
            chk($sformatf("atk_state[%0d]", i), int'(st0), e);
            chk($sformatf("atk_active[%0d]", i), int'(act0), (e == 4) ? 1 : 0);
            if (!held) chk($sformatf("atk_posx[%0d]", i), int'(posx0), 210);
            if (e == 4 && !held) begin
                chk("hitbox_x1", int'(hb0_x1), 296);
                chk("hitbox_x2", int'(hb0_x2), 340);
                chk("hitbox_y1", int'(hb0_y1), 194);
                chk("hitbox_y2", int'(hb0_y2), 227);
            end
        end
        a0 = 1'b0;
    endtask

    initial begin
        // l, r, a -> state, posx, attack_active after the edge (SIDE 0)
        vecs[0]  = '{0, 1, 0, 1, 210, 0};
        vecs[1]  = '{0, 1, 0, 1, 225, 0};
        vecs[2]  = '{0, 1, 0, 1, 240, 0};
        vecs[3]  = '{0, 0, 0, 0, 255, 0};
        vecs[4]  = '{0, 0, 0, 0, 255, 0};
        vecs[5]  = '{1, 0, 0, 2, 255, 0};
        vecs[6]  = '{0, 0, 0, 0, 240, 0};
        vecs[7]  = '{1, 1, 0, 2, 240, 0};
        vecs[8]  = '{0, 0, 0, 0, 225, 0};
        vecs[9]  = '{0, 1, 1, 3, 225, 0};
        vecs[10] = '{1, 0, 0, 3, 225, 0};
        vecs[11] = '{0, 1, 0, 3, 225, 0};
        vecs[12] = '{0, 0, 0, 3, 225, 0};
        vecs[13] = '{0, 0, 1, 4, 225, 1};
        vecs[14] = '{0, 1, 0, 5, 225, 0};

        do_reset();
        chk("rst_state0", int'(st0), 0);
        chk("rst_posx0", int'(posx0), 210);
        chk("rst_posy0", int'(posy0), 170);
        chk("rst_active0", int'(act0), 0);
        chk("rst_hurt0_x1", int'(hu0_x1), 247);
        chk("rst_hurt0_x2", int'(hu0_x2), 296);
        chk("rst_hurt0_y1", int'(hu0_y1), 170);
        chk("rst_hurt0_y2", int'(hu0_y2), 320);
        chk("rst_state1", int'(st1), 0);
        chk("rst_posx1", int'(posx1), 420);

        for (int i = 0; i < 15; i++) begin
            l0 = vecs[i].l;
            r0 = vecs[i].r;
            a0 = vecs[i].a;
            tick();
            chk($sformatf("vec%0d_state", i), int'(st0), vecs[i].st);
            chk($sformatf("vec%0d_posx", i), int'(posx0), vecs[i].px);
            chk($sformatf("vec%0d_active", i), int'(act0), int'(vecs[i].act));
        end

        run_atk(1'b0, 22);
        run_atk(1'b1, 23);

        // SIDE 1 boxes, retreat with both held, then clamp at X_MIN
        do_reset();
        chk("s1_hurt_x1", int'(hu1_x1), 484);
        chk("s1_hurt_x2", int'(hu1_x2), 533);
        chk("s1_hit_x1", int'(hb1_x1), 440);
        chk("s1_hit_x2", int'(hb1_x2), 484);
        l1 = 1'b1; r1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("s1_back_state[%0d]", i), int'(st1), 2);
            chk($sformatf("s1_back_posx[%0d]", i), int'(posx1), 420 + 15 * i);
        end
        r1 = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("s1_min_state", int'(st1), 1);
        chk("s1_min_posx", int'(posx1), 50);
        tick();
        tick();
        chk("s1_min_hold", int'(posx1), 50);
        l1 = 1'b0;

        // SIDE 0 clamp at X_MAX
        do_reset();
        r0 = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        chk("s0_max_posx", int'(posx0), 490);
        tick();
        tick();
        chk("s0_max_hold", int'(posx0), 490);
        chk("s0_max_state", int'(st0), 1);
        r0 = 1'b0;

`ifdef FIGHTER_HITSTUN_EN
        // Hit during ATK_START, second hit mid-stun must not extend it
        do_reset();
        a0 = 1'b1;
        tick();
        a0 = 1'b0;
        tick();
        h0 = 1'b1;
        tick();
        h0 = 1'b0;
        chk("hs_enter_state", int'(st0), 6);
        chk("hs_enter_active", int'(act0), 0);
        chk("hs_enter_posx", int'(posx0), 210);
        for (int i = 1; i < 14; i++) begin
            if (i == 5) h0 = 1'b1;
            tick();
            h0 = 1'b0;
            chk($sformatf("hs_state[%0d]", i), int'(st0), (i < 12) ? 6 : 0);
            chk($sformatf("hs_posx[%0d]", i), int'(posx0), (i <= 12) ? 210 - 8 * i : 114);
            chk($sformatf("hs_active[%0d]", i), int'(act0), 0);
        end

        // Hit on the last ATK_START cycle wins over the phase expiry
        do_reset();
        a0 = 1'b1;
        tick();
        a0 = 1'b0;
        tick();
        tick();
        tick();
        h0 = 1'b1;
        tick();
        h0 = 1'b0;
        chk("hs_race_state", int'(st0), 6);
        chk("hs_race_active", int'(act0), 0);

        // Hit while ATK_ACTIVE drops attack_active on the next edge
        do_reset();
        a0 = 1'b1;
        tick();
        a0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("hs_act_pre", int'(act0), 1);
        h0 = 1'b1;
        tick();
        h0 = 1'b0;
        chk("hs_act_state", int'(st0), 6);
        chk("hs_act_active", int'(act0), 0);
`else
        // hit is ignored in every state
        do_reset();
        h0 = 1'b1;
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        chk("nohs_move_state", int'(st0), 1);
        a0 = 1'b1;
        tick();
        a0 = 1'b0;
        tick();
        chk("nohs_atk_state", int'(st0), 3);
        chk("nohs_atk_posx", int'(posx0), 225);
        h0 = 1'b0;
`endif

        // Asynchronous reset in the middle of ATK_RECOVER
        do_reset();
        r0 = 1'b1;
        tick();
        tick();
        r0 = 1'b0;
        a0 = 1'b1;
        tick();
        a0 = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("mid_rec_state", int'(st0), 5);
        chk("mid_rec_posx", int'(posx0), 240);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(st0), 0);
        chk("async_rst_posx", int'(posx0), 210);
        chk("async_rst_active", int'(act0), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_state", int'(st0), 0);
        chk("post_rst_posx", int'(posx0), 210);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fighter_ctrl.md
# fighter_ctrl

Parametrised per-player fighter controller. It is the next generation of the player state machine: configurable speed, arena bounds and attack phase lengths, saturating position arithmetic, a registered attack-active flag and mirrored hit/hurt boxes. An optional hitstun/knockback reaction can be compiled in. One instance per player sits between the input decoder and the collision/render logic.

## Interface
- SIDE, 0: 0 = left player (faces +x), 1 = right player (faces −x)
- X_W, 10: width of position and box coordinates
- SPEED, 15: pixels moved per cycle in a move state
- X_MIN / X_MAX, 50 / 490: inclusive posx clamp bounds
- X_RST_L / X_RST_R, 210 / 420: reset posx for SIDE 0 / 1
- POS_Y, 170: fixed posy
- SPRITE_W, 150: sprite width, used for mirroring
- T_START / T_ACTIVE / T_RECOVER, 4 / 1 / 15: attack phase lengths in cycles, each ≥ 1
- T_HITSTUN / KNOCKBACK, 12 / 8: hitstun length in cycles, and knockback pixels per cycle
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- left, right, attack  in  1 each  level-sensitive controls
- hit  in  1  single-cycle "was struck" pulse from collision logic
- posx, posy  out  X_W each  sprite origin
- state  out  4  current state encoding
- attack_active  out  1  hitbox valid
- hitbox_x1/x2/y1/y2  out  X_W each  attack box, x1 ≤ x2
- hurtbox_x1/x2/y1/y2  out  X_W each  body box, x1 ≤ x2

## Operation
- States: IDLE=0, FWD=1, BACK=2, ATK_START=3, ATK_ACTIVE=4, ATK_RECOVER=5, HITSTUN=6. Codes 7–15 go to IDLE on the next cycle.
- Neutral states (IDLE/FWD/BACK) use this priority order: hit (macro on) > attack → ATK_START > left&right → BACK > single direction → FWD if toward the opponent, else BACK > none → IDLE.
  - SIDE 0: right is forward. SIDE 1: left is forward.
- Attack chain: ATK_START → ATK_ACTIVE → ATK_RECOVER → IDLE. Each phase lasts exactly its T_* cycles.
  - The phase counter clears on state entry. The state exits when count == T−1.
  - Movement and attack inputs are ignored during the chain.
  - A held attack re-enters ATK_START after exactly one IDLE cycle.
- posx update is based on the registered state: FWD moves ±SPEED toward the opponent; BACK moves away; HITSTUN moves KNOCKBACK away; all other states hold.
- Arithmetic is done in X_W+1 bits signed, then clamped to [X_MIN, X_MAX]. It never wraps.
- attack_active is 1 only in ATK_ACTIVE.
- Hitbox:
  - y: POS_Y+24 .. POS_Y+57.
  - x, SIDE 0: posx+86 .. posx+130.
  - x, SIDE 1: posx+SPRITE_W−130 .. posx+SPRITE_W−86.
- Hurtbox:
  - y: POS_Y .. POS_Y+150.
  - x, SIDE 0: posx+37 .. posx+86.
  - x, SIDE 1: posx+SPRITE_W−86 .. posx+SPRITE_W−37.
- Box outputs are combinational from posx and are driven even when attack_active is 0.

## Timing
- Reset values: state=IDLE, counter=0, posx=X_RST_L or X_RST_R, posy=POS_Y, attack_active=0. Boxes follow posx.
- rst asserted mid-attack or mid-hitstun aborts immediately. The first cycle after release evaluates from IDLE.
- Latency: inputs sampled at edge k set state at edge k; posx reflects that state at edge k+1.
- hit is sampled on the same edge as the other inputs and overrides them.
- A hit arriving in the same cycle as a phase expiry still wins: the block goes to HITSTUN.
- Clamp applies every cycle, including the knockback cycle that reaches a bound.

## Configuration
- FIGHTER_HITSTUN_EN defined:
  - A hit in any state except HITSTUN goes to HITSTUN for T_HITSTUN cycles, then IDLE.
  - A hit during HITSTUN is ignored and does not restart the timer.
  - A hit during an attack cancels the attack and drops attack_active the next cycle.
- FIGHTER_HITSTUN_EN undefined: the hit port exists but is ignored, HITSTUN is unreachable, and T_HITSTUN/KNOCKBACK are unused.

## Structure
- fighter_pkg holds: the state enum (4-bit), box offset constants (24/57/37/86/130/150), and a box struct {x1,x2,y1,y2}.
- Sub-module phase_timer: a counter with clear, a terminal-count compare against a runtime length, and a done output. It is shared by the attack phases and hitstun.

## Test plan
- SIDE 0, right held 3 cycles after reset → state FWD; posx 210→225→240→255. Release → IDLE and posx holds.
- SIDE 0 at posx 485, right held → posx 490 and stays 490 (no wrap). SIDE 1 at 55, left held → 50.
- SIDE 0 idle at 210, 1-cycle attack pulse → ATK_START 4 cycles, ATK_ACTIVE 1, ATK_RECOVER 15, IDLE. attack_active high exactly 1 cycle with hitbox x 296..340, y 194..227.
- SIDE 1, left+right held → BACK; posx 420→435→450. Hurtbox x at 420 is 484..533.
- Macro on, SIDE 0 at 210, hit during ATK_START → HITSTUN 12 cycles, posx ends 114, attack_active never asserted. A second hit mid-stun does not extend it.
- Reset asserted mid-ATK_RECOVER → state, posx and attack_active take reset values before the next clock edge.
